tx_frame_controller: RTL and testbench

TX_FRAME_CONTROLLER -- requirements
Module: tx_frame_controller

---
 rtl/tx_pkg.sv | 27 ++
 rtl/tx_frame_controller_if.sv | 18 +
 rtl/tx_checksum.sv | 21 ++
 rtl/tx_frame_controller.sv | 139 +++++++++++++
 tb/tb_tx_frame_controller.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_pkg.sv
// tx_pkg -- shared types and constants for the frame transmitter.
//   tx_state_e    : controller state encoding
//   PREAMBLE_BYTE : preamble fill byte (0xAA)
//   SFD_BYTE      : start-of-frame delimiter (0xD5)
//   is_tx_state() : true for states that present a byte to the serializer
package tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_LEN,
    ST_FETCH,
    ST_CAPTURE,
    ST_PAYLOAD,
    ST_CSUM,
    ST_GAP
  } tx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  function automatic logic is_tx_state(input tx_state_e s);
    return s inside {ST_PREAMBLE, ST_SFD, ST_LEN, ST_PAYLOAD, ST_CSUM};
  endfunction

endpackage

// File: rtl/tx_frame_controller_if.sv
// tx_frame_controller_if -- buffer read port and serializer byte handshake.
//   buf_ready/buf_data/rdreq : input buffer side (non-showahead read)
//   tx_data/tx_valid/tx_ready: serializer side (valid/ready)
//   master : the frame controller
//   slave  : the buffer + serializer environment
interface tx_frame_controller_if;
  logic       buf_ready;
  logic [7:0] buf_data;
  logic       rdreq;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (input  buf_ready, buf_data, tx_ready,
                  output rdreq, tx_data, tx_valid);
  modport slave  (output buf_ready, buf_data, tx_ready,
                  input  rdreq, tx_data, tx_valid);
endinterface

// File: rtl/tx_checksum.sv
// tx_checksum -- 8-bit XOR accumulator.
//   rdclk, arst : clock, async active-high reset
//   clear       : zero the accumulator (wins over en)
//   en, din     : fold din into the accumulator
//   csum        : current accumulated value
module tx_checksum (
  input  logic       rdclk,
  input  logic       arst,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] csum
);

  always_ff @(posedge rdclk or posedge arst) begin
    if (arst)       csum <= 8'h00;
    else if (clear) csum <= 8'h00;
    else if (en)    csum <= csum ^ din;
  end

endmodule

// File: rtl/tx_frame_controller.sv
// tx_frame_controller -- reads PAYLOAD_LEN bytes from a non-showahead buffer
// and sends: PREAMBLE_LEN x 0xAA, 0xD5, length, payload, XOR checksum,
// followed by IFG_LEN idle cycles.
//   rdclk, arst  : sole clock, async active-high reset
//   enable       : permits starting new frames (never aborts one)
//   busy         : controller not idle
//   frame_count  : completed frames, wraps
//   bus (master) : buffer read port + serializer valid/ready
// All outputs come straight from flops: the output process decodes the
// *next* state and the results are registered alongside it.
module tx_frame_controller
  import tx_pkg::*;
#(
  parameter int PREAMBLE_LEN = 4,
  parameter int PAYLOAD_LEN  = 10,
  parameter int IFG_LEN      = 3
) (
  input  logic                  rdclk,
  input  logic                  arst,
  input  logic                  enable,
  output logic                  busy,
  output logic [15:0]           frame_count,
  tx_frame_controller_if.master bus
);

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
  localparam logic [3:0] PAY_LAST = 4'(PAYLOAD_LEN - 1);
  localparam logic [3:0] GAP_LAST = 4'(IFG_LEN - 1);
  localparam logic [7:0] LEN_BYTE = 8'(PAYLOAD_LEN);

  tx_state_e   state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        acc;
  logic [7:0]  csum;
  logic        cs_clear, cs_en;
  logic        tx_valid_d, rdreq_d, busy_d;
  logic [7:0]  tx_data_d;
  logic [15:0] frame_cnt_q;

  assign acc         = bus.tx_valid & bus.tx_ready;
  assign frame_count = frame_cnt_q;

  // checksum restarts with each frame and folds every byte as it is captured
  assign cs_clear = (state == ST_IDLE) && (state_d == ST_PREAMBLE);
  assign cs_en    = (state == ST_CAPTURE);

  tx_checksum u_csum (
    .rdclk (rdclk),
    .arst  (arst),
    .clear (cs_clear),
    .en    (cs_en),
    .din   (bus.buf_data),
    .csum  (csum)
  );

  // state register (with registered outputs)
  always_ff @(posedge rdclk or posedge arst) begin
    if (arst) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      bus.rdreq    <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= 8'h00;
      busy         <= 1'b0;
      frame_cnt_q  <= 16'h0000;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      bus.rdreq    <= rdreq_d;
      bus.tx_valid <= tx_valid_d;
      bus.tx_data  <= tx_data_d;
      busy         <= busy_d;
      if (state == ST_CSUM && acc) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // next state; cnt counts preamble bytes, payload bytes, then gap cycles
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_IDLE:
        if (enable && bus.buf_ready) begin
          state_d = ST_PREAMBLE;
          cnt_d   = 4'd0;
        end
      ST_PREAMBLE:
        if (acc) begin
          if (cnt == PRE_LAST) begin
            state_d = ST_SFD;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt + 4'd1;
          end
        end
      ST_SFD:     if (acc) state_d = ST_LEN;
      ST_LEN:     if (acc) state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_PAYLOAD;
      ST_PAYLOAD:
        if (acc) begin
          if (cnt == PAY_LAST) begin
            state_d = ST_CSUM;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_FETCH;
            cnt_d   = cnt + 4'd1;
          end
        end
      ST_CSUM:
        if (acc) begin
          cnt_d   = 4'd0;
          state_d = (IFG_LEN == 0) ? ST_IDLE : ST_GAP;
        end
      ST_GAP:
        if (cnt == GAP_LAST) state_d = ST_IDLE;
        else                 cnt_d = cnt + 4'd1;
      default: state_d = ST_IDLE;
    endcase
  end

  // outputs for the coming cycle, keyed on state_d so they can be registered
  always_comb begin
    tx_valid_d = is_tx_state(state_d);
    rdreq_d    = (state_d == ST_FETCH);
    busy_d     = (state_d != ST_IDLE);
    tx_data_d  = bus.tx_data;
    case (state_d)
      ST_PREAMBLE: tx_data_d = PREAMBLE_BYTE;
      ST_SFD:      tx_data_d = SFD_BYTE;
      ST_LEN:      tx_data_d = LEN_BYTE;
      // buf_data is only valid during CAPTURE; later PAYLOAD cycles hold it
      ST_PAYLOAD:  if (state == ST_CAPTURE) tx_data_d = bus.buf_data;
      ST_CSUM:     tx_data_d = csum;
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_tx_frame_controller.sv
module tb_tx_frame_controller;

  localparam int PRE = 4;
  localparam int PAY = 10;
  localparam int IFG = 3;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } exp_t;

  logic        rdclk = 1'b0;
  logic        arst;
  logic        enable;
  logic        busy;
  logic [15:0] frame_count;

  tx_frame_controller_if bus();

  tx_frame_controller #(.PREAMBLE_LEN(PRE), .PAYLOAD_LEN(PAY), .IFG_LEN(IFG)) dut (
    .rdclk       (rdclk),
    .arst        (arst),
    .enable      (enable),
    .busy        (busy),
    .frame_count (frame_count),
    .bus         (bus.master)
  );

  always #5 rdclk = ~rdclk;

  int checks = 0;
  int fails  = 0;

  exp_t       expq[$];
  logic [7:0] bufq[$];

  int rmode = 0;        // 0 ready, 1 toggle, 2 random, 3 held low
  int rd_in_frame = 0;
  int rd_total = 0;
  int gap_cnt = -1;
  bit gap_chk = 0;
  bit pend = 0;
  logic [7:0] pend_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // reference frame built from the frame format rules
  task automatic issue_frame(input bit rnd);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    for (int i = 0; i < PRE; i++) expq.push_back('{8'hAA, 1'b0});
    expq.push_back('{8'hD5, 1'b0});
    expq.push_back('{8'(PAY), 1'b0});
    for (int i = 0; i < PAY; i++) begin
      b = rnd ? 8'($urandom) : 8'(i + 1);
      bufq.push_back(b);
      expq.push_back('{b, 1'b0});
      x = x ^ b;
    end
    expq.push_back('{x, 1'b1});
  endtask

  // serializer ready pattern
  always @(posedge rdclk) begin
    #1;
    case (rmode)
      0: bus.tx_ready = 1'b1;
      1: bus.tx_ready = ~bus.tx_ready;
      2: bus.tx_ready = 1'($urandom_range(0, 1));
      default: bus.tx_ready = 1'b0;
    endcase
  end

  // non-showahead buffer: data appears the cycle after rdreq
  always @(posedge rdclk) begin
    if (!arst && bus.rdreq) begin
      if (bufq.size() > 0) bus.buf_data <= bufq.pop_front();
      else                 bus.buf_data <= 8'hEE;
    end
  end

  // monitor / scoreboard
  always @(negedge rdclk) begin
    exp_t e;
    if (arst) begin
      pend        = 0;
      rd_in_frame = 0;
      gap_cnt     = -1;
    end else begin
      if (bus.rdreq) begin
        rd_in_frame++;
        rd_total++;
        check("rdreq_with_valid", {31'd0, bus.tx_valid}, 32'd0);
      end
      if (pend) begin
        check("hold_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("hold_data", {24'd0, bus.tx_data}, {24'd0, pend_data});
      end
      if (bus.tx_valid) begin
        if (gap_cnt >= 0) begin
          if (gap_chk) check("ifg_cycles", gap_cnt, IFG + 1);
          gap_cnt = -1;
        end
        if (bus.tx_ready) begin
          pend = 0;
          if (expq.size() == 0) begin
            check("unexpected_byte", {24'd0, bus.tx_data}, 32'h100);
          end else begin
            e = expq.pop_front();
            check("tx_byte", {24'd0, bus.tx_data}, {24'd0, e.d});
            if (e.last) begin
              check("rdreq_per_frame", rd_in_frame, PAY);
              rd_in_frame = 0;
              gap_cnt     = 0;
            end
          end
        end else begin
          pend      = 1;
          pend_data = bus.tx_data;
        end
      end else if (gap_cnt >= 0) begin
        gap_cnt++;
      end
    end
  end

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 200) begin @(posedge rdclk); #1; n++; end
    check("frame_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin @(posedge rdclk); #1; n++; end
    check("reach_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_fc(input logic [15:0] v);
    int n = 0;
    while (frame_count !== v && n < 3000) begin @(posedge rdclk); #1; n++; end
    check("frame_count", {16'd0, frame_count}, {16'd0, v});
  endtask

  task automatic one_frame(input bit rnd, input logic [15:0] fc_after);
    issue_frame(rnd);
    enable = 1'b1;
    wait_busy();
    enable = 1'b0;
    wait_fc(fc_after);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int rd_snap;
    arst          = 1'b1;
    enable        = 1'b0;
    bus.buf_ready = 1'b0;
    bus.tx_ready  = 1'b1;
    repeat (3) @(posedge rdclk);
    #1;
    check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("rst_rdreq", {31'd0, bus.rdreq}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    arst = 1'b0;
    @(posedge rdclk); #1;

    // incrementing payload, ready always; enable dropped in the preamble
    rmode = 0;
    bus.buf_ready = 1'b1;
    one_frame(1'b0, 16'd1);
    repeat (40) @(posedge rdclk);
    #1;
    check("no_restart_busy", {31'd0, busy}, 32'd0);
    check("no_restart_count", {16'd0, frame_count}, 32'd1);

    // ready toggling every cycle
    rmode = 1;
    one_frame(1'b0, 16'd2);

    // back-to-back frames with buf_ready held: measure inter-frame gap
    rmode = 0;
    issue_frame(1'b1);
    issue_frame(1'b1);
    enable = 1'b1;
    wait_busy();
    gap_chk = 1;
    wait_fc(16'd3);
    n = 0;
    while (!bus.tx_valid && n < 100) begin @(posedge rdclk); #1; n++; end
    check("second_start", {31'd0, bus.tx_valid}, 32'd1);
    enable = 1'b0;
    @(posedge rdclk); #1;
    gap_chk = 0;
    wait_fc(16'd4);
    wait_idle();

    // long stall: no reads, byte held
    issue_frame(1'b1);
    enable = 1'b1;
    wait_busy();
    enable = 1'b0;
    repeat (12) @(posedge rdclk);
    rmode = 3;
    repeat (4) @(posedge rdclk);
    #1;
    rd_snap = rd_total;
    repeat (40) @(posedge rdclk);
    #1;
    check("stall_no_rdreq", rd_total, rd_snap);
    check("stall_valid", {31'd0, bus.tx_valid}, 32'd1);
    rmode = 0;
    wait_fc(16'd5);
    wait_idle();

    // random payloads with random ready
    rmode = 2;
    for (int f = 0; f < 3; f++) one_frame(1'b1, 16'(6 + f));
    rmode = 0;

    // reset while the 5th payload byte is presented
    issue_frame(1'b0);
    enable = 1'b1;
    wait_busy();
    enable = 1'b0;
    n = 0;
    while (!(rd_in_frame == 5 && bus.tx_valid) && n < 500) begin
      @(posedge rdclk); #1; n++;
    end
    check("reach_payload5", rd_in_frame, 5);
    #1;
    arst = 1'b1;
    expq.delete();
    bufq.delete();
    #1;
    check("arst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("arst_rdreq", {31'd0, bus.rdreq}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("arst_frame_count", {16'd0, frame_count}, 32'd0);
    repeat (2) @(posedge rdclk);
    #1;
    arst = 1'b0;
    one_frame(1'b1, 16'd1);

    // counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge rdclk); #1;
    release dut.frame_cnt_q;
    @(posedge rdclk); #1;
    check("preload", {16'd0, frame_count}, 32'hFFFF);
    one_frame(1'b1, 16'h0000);

    repeat (5) @(posedge rdclk);
    #1;
    check("expq_drained", expq.size(), 0);
    check("buf_drained", bufq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
